// File: rtl/forward_hazard_unit.sv
// Operand-forwarding selects/data for the EX operand mux, registered at ID/EX,
// plus load-use stall detection against the instruction in EX.
module forward_hazard_unit #(
  parameter int N = 24,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [R-1:0] id_rs1,
  input  logic [R-1:0] id_rs2,
  input  logic [R-1:0] id_rs3,
  input  logic         id_use1,
  input  logic         id_use2,
  input  logic         id_use3,
  input  logic         ex_regWrite,
  input  logic         ex_memToReg,
  input  logic [R-1:0] ex_rd,
  input  logic [N-1:0] ex_aluResult,
  input  logic [N-1:0] mem_readData,
  input  logic         flush,
  output logic         stall,
  output logic         Fa,
  output logic         Fb,
  output logic         Fc,
  output logic [N-1:0] Forward1,
  output logic [N-1:0] Forward2,
  output logic [N-1:0] Forward3,
  output logic [15:0]  stallCount
);

  logic         mem_valid;
  logic         mem_load;
  logic [R-1:0] mem_rd;
  logic [N-1:0] mem_alu;
  logic         wb_valid;
  logic [R-1:0] wb_rd;
  logic [N-1:0] wb_value;

  logic [R-1:0] rs    [3];
  logic [2:0]   use_v;
  logic [2:0]   ex_hit;
  logic [2:0]   sel_hit;
  logic [N-1:0] sel_data [3];
  logic         clear_out;

  always_comb begin
    rs[0] = id_rs1;
    rs[1] = id_rs2;
    rs[2] = id_rs3;
    use_v = {id_use3, id_use2, id_use1};
  end

  // Per-source producer match in priority order EX > MEM > WB; r0 never forwards.
  always_comb begin
    ex_hit = '0;
    for (int k = 0; k < 3; k++) begin
      sel_hit[k]  = 1'b0;
      sel_data[k] = '0;
      ex_hit[k]   = use_v[k] && (rs[k] == ex_rd);
      if (use_v[k] && rs[k] != '0) begin
        if (ex_regWrite && ex_rd == rs[k]) begin
          sel_hit[k]  = 1'b1;
          sel_data[k] = ex_aluResult;
        end else if (mem_valid && mem_rd == rs[k]) begin
          sel_hit[k]  = 1'b1;
          sel_data[k] = mem_load ? mem_readData : mem_alu;
        end else if (wb_valid && wb_rd == rs[k]) begin
          sel_hit[k]  = 1'b1;
          sel_data[k] = wb_value;
        end
      end
    end
  end

  assign stall = id_valid && !flush && ex_regWrite && ex_memToReg &&
                 (ex_rd != '0) && (|ex_hit);

  assign clear_out = stall || flush || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_load   <= 1'b0;
      mem_rd     <= '0;
      mem_alu    <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_value   <= '0;
      stallCount <= '0;
      Fa         <= 1'b0;
      Fb         <= 1'b0;
      Fc         <= 1'b0;
      Forward1   <= '0;
      Forward2   <= '0;
      Forward3   <= '0;
    end else begin
      // Tracker shifts every cycle; a stall bubble shows up via ex_regWrite=0.
      mem_valid <= ex_regWrite;
      mem_load  <= ex_memToReg;
      mem_rd    <= ex_rd;
      mem_alu   <= ex_aluResult;
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_value  <= mem_load ? mem_readData : mem_alu;
      if (stall && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      if (clear_out) begin
        Fa       <= 1'b0;
        Fb       <= 1'b0;
        Fc       <= 1'b0;
        Forward1 <= '0;
        Forward2 <= '0;
        Forward3 <= '0;
      end else begin
        Fa       <= sel_hit[0];
        Fb       <= sel_hit[1];
        Fc       <= sel_hit[2];
        Forward1 <= sel_data[0];
        Forward2 <= sel_data[1];
        Forward3 <= sel_data[2];
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: vector table for forwarding paths,
// hand sequences for load-use, flush, reset and stall-count saturation.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rs3;
  logic        id_use1, id_use2, id_use3;
  logic        ex_regWrite, ex_memToReg;
  logic [3:0]  ex_rd;
  logic [23:0] ex_aluResult, mem_readData;
  logic        flush;
  logic        stall;
  logic        Fa, Fb, Fc;
  logic [23:0] Forward1, Forward2, Forward3;
  logic [15:0] stallCount;

  int total = 0;
  int bad   = 0;

  forward_hazard_unit #(.N(24), .R(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg), .ex_rd(ex_rd),
    .ex_aluResult(ex_aluResult), .mem_readData(mem_readData), .flush(flush),
    .stall(stall), .Fa(Fa), .Fb(Fb), .Fc(Fc),
    .Forward1(Forward1), .Forward2(Forward2), .Forward3(Forward3),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  rs1, rs2, rs3;
    logic        u1, u2, u3;
    logic        rw, ml;
    logic [3:0]  rd;
    logic [23:0] alu, mrd;
    logic        fl;
    logic        e_stall;
    logic        e_fa, e_fb, e_fc;
    logic [23:0] e_f1, e_f2, e_f3;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rs3, input logic u1, input logic u2, input logic u3,
                       input logic rw, input logic ml, input logic [3:0] rd,
                       input logic [23:0] alu, input logic [23:0] mrd, input logic fl);
    id_valid = vld; id_rs1 = rs1; id_rs2 = rs2; id_rs3 = rs3;
    id_use1 = u1; id_use2 = u2; id_use3 = u3;
    ex_regWrite = rw; ex_memToReg = ml; ex_rd = rd;
    ex_aluResult = alu; mem_readData = mrd; flush = fl;
  endtask

  task automatic check_out(input string tag, input logic fa, input logic fb, input logic fc,
                           input logic [23:0] f1, input logic [23:0] f2, input logic [23:0] f3);
    check({tag, ".Fa"}, {31'd0, Fa}, {31'd0, fa});
    check({tag, ".Fb"}, {31'd0, Fb}, {31'd0, fb});
    check({tag, ".Fc"}, {31'd0, Fc}, {31'd0, fc});
    check({tag, ".Forward1"}, {8'd0, Forward1}, {8'd0, f1});
    check({tag, ".Forward2"}, {8'd0, Forward2}, {8'd0, f2});
    check({tag, ".Forward3"}, {8'd0, Forward3}, {8'd0, f3});
  endtask

  initial begin
    //          vld  rs1   rs2   rs3   u1    u2    u3    rw    ml    rd    alu          mrd          fl    stall fa    fb    fc    f1           f2           f3
    vecs[0] = '{1'b1,4'd3,4'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,4'd3,24'h000123,24'h000000,1'b0,1'b0,1'b1,1'b0,1'b0,24'h000123,24'h000000,24'h000000};
    vecs[1] = '{1'b1,4'd3,4'd4,4'd7,1'b1,1'b1,1'b1,1'b1,1'b0,4'd4,24'h000456,24'h000999,1'b0,1'b0,1'b1,1'b1,1'b0,24'h000123,24'h000456,24'h000000};
    vecs[2] = '{1'b1,4'd3,4'd4,4'd3,1'b1,1'b1,1'b1,1'b0,1'b0,4'd3,24'h000BAD,24'h000000,1'b0,1'b0,1'b1,1'b1,1'b1,24'h000123,24'h000456,24'h000123};
    vecs[3] = '{1'b0,4'd4,4'd0,4'd0,1'b1,1'b0,1'b0,1'b1,1'b0,4'd1,24'h000001,24'h000000,1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,24'h000000};
    vecs[4] = '{1'b1,4'd0,4'd1,4'd1,1'b1,1'b0,1'b1,1'b1,1'b0,4'd0,24'h000777,24'h000000,1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,24'h000000,24'h000001};
    vecs[5] = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,24'h000011,24'h000000,1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,24'h000000};
    vecs[6] = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,24'h000022,24'h000000,1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,24'h000000};
    vecs[7] = '{1'b1,4'd2,4'd0,4'd2,1'b0,1'b0,1'b1,1'b1,1'b0,4'd2,24'h000033,24'h000000,1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,24'h000000,24'h000033};
    vecs[8] = '{1'b1,4'd2,4'd2,4'd0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0,24'h000000,24'h000555,1'b0,1'b0,1'b1,1'b1,1'b0,24'h000033,24'h000033,24'h000000};
    vecs[9] = '{1'b1,4'd9,4'd2,4'd0,1'b0,1'b1,1'b0,1'b1,1'b1,4'd9,24'h000000,24'h000000,1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,24'h000033,24'h000000};

    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
    check("reset.stallCount", {16'd0, stallCount}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, vecs[i].u1, vecs[i].u2,
            vecs[i].u3, vecs[i].rw, vecs[i].ml, vecs[i].rd, vecs[i].alu, vecs[i].mrd, vecs[i].fl);
      #1;
      check($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_fc,
                vecs[i].e_f1, vecs[i].e_f2, vecs[i].e_f3);
    end

    // load-use: load r5 in EX, decode reads rs2=r5
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 24'h000100, 24'h0, 1'b0);
    #1;
    check("lu.stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    check_out("lu.bubble", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
    check("lu.cnt1", {16'd0, stallCount}, 32'd1);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'hABCDEF, 1'b0);
    #1;
    check("lu.stall2", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_out("lu.fwd", 1'b0, 1'b1, 1'b0, 24'h0, 24'hABCDEF, 24'h0);
    check("lu.cnt2", {16'd0, stallCount}, 32'd1);

    // flush overrides a load-use hazard
    @(negedge clk);
    drive(1'b1, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 24'h000200, 24'h0, 1'b1);
    #1;
    check("fl.stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_out("fl", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
    check("fl.cnt", {16'd0, stallCount}, 32'd1);

    @(negedge clk);
    drive(1'b1, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 24'h000ABC, 24'h0, 1'b0);
    @(posedge clk); #1;
    check_out("pre_rst", 1'b1, 1'b0, 1'b0, 24'h000ABC, 24'h0, 24'h0);

    // reset during a stall clears outputs, counter and tracker
    @(negedge clk);
    drive(1'b1, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 24'h000300, 24'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst.stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    check_out("rst", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
    check("rst.cnt", {16'd0, stallCount}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'd6, 4'd7, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 24'h00F00D, 1'b0);
    @(posedge clk); #1;
    check_out("post_rst", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);

    // hold a load-use hazard to saturate the stall counter
    @(negedge clk);
    drive(1'b1, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 24'h0, 24'h0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", {16'd0, stallCount}, 32'h0000FFFE);
    repeat (2) @(posedge clk);
    #1;
    check("sat.ffff", {16'd0, stallCount}, 32'h0000FFFF);
    check_out("sat", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
